// File: rtl/sc_point_datapath_pkg.sv
// Shared definitions for the point game: shift-select encodings and the
// default geometry/timing used by the datapath, state machine and top level.
package sc_point_datapath_pkg;

  // Encoding of the two-bit shift select issued by the point state machine.
  typedef enum logic [1:0] {
    SHIFT_NONE  = 2'b00,
    SHIFT_LEFT  = 2'b01,
    SHIFT_RIGHT = 2'b10,
    SHIFT_HOLD  = 2'b11
  } shift_sel_e;

  localparam int          DEF_WIDTH      = 8;
  localparam int          DEF_ROWS       = 8;
  localparam int          DEF_ROW_BITS   = 3;
  localparam int          DEF_TICK_DIV   = 25000000;
  localparam int          DEF_TICK_BITS  = 25;
  localparam logic [7:0]  DEF_INIT_POINT = 8'b0001_0000;

endpackage

// File: rtl/sc_point_datapath_if.sv
// Control/T0 bundle between the point state machine (master) and the
// datapath (slave). The datapath answers strobes and raises the T0 request.
interface sc_point_datapath_if #(
  parameter int WIDTH    = 8,
  parameter int ROW_BITS = 3
);
  logic                SC_POINTDATAPATH_clear_InLow;
  logic                SC_POINTDATAPATH_load0_InLow;
  logic [1:0]          SC_POINTDATAPATH_shiftselection_In;
  logic                SC_POINTDATAPATH_mux_In;
  logic [WIDTH-1:0]    SC_POINTDATAPATH_data_In;
  logic [WIDTH-1:0]    SC_POINTDATAPATH_point_Out;
  logic [ROW_BITS-1:0] SC_POINTDATAPATH_row_Out;
  logic                SC_POINTDATAPATH_T0_OutLow;
  logic                SC_POINTDATAPATH_bottom_OutHigh;
  logic                SC_POINTDATAPATH_overrun_OutHigh;

  modport master (
    output SC_POINTDATAPATH_clear_InLow,
    output SC_POINTDATAPATH_load0_InLow,
    output SC_POINTDATAPATH_shiftselection_In,
    output SC_POINTDATAPATH_mux_In,
    output SC_POINTDATAPATH_data_In,
    input  SC_POINTDATAPATH_point_Out,
    input  SC_POINTDATAPATH_row_Out,
    input  SC_POINTDATAPATH_T0_OutLow,
    input  SC_POINTDATAPATH_bottom_OutHigh,
    input  SC_POINTDATAPATH_overrun_OutHigh
  );

  modport slave (
    input  SC_POINTDATAPATH_clear_InLow,
    input  SC_POINTDATAPATH_load0_InLow,
    input  SC_POINTDATAPATH_shiftselection_In,
    input  SC_POINTDATAPATH_mux_In,
    input  SC_POINTDATAPATH_data_In,
    output SC_POINTDATAPATH_point_Out,
    output SC_POINTDATAPATH_row_Out,
    output SC_POINTDATAPATH_T0_OutLow,
    output SC_POINTDATAPATH_bottom_OutHigh,
    output SC_POINTDATAPATH_overrun_OutHigh
  );
endinterface

// File: rtl/sc_point_datapath_prescaler.sv
// Move-tick generator: free-running prescaler that raises the active-low T0
// request at terminal count, holds it until load0 acknowledges it, and flags
// a sticky overrun when a tick arrives while the previous one is unanswered.
module sc_tick_prescaler
  import sc_point_datapath_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int TICK_BITS = DEF_TICK_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_InLow,
  input  logic load0_InLow,
  output logic T0_OutLow,
  output logic overrun_OutHigh
);

  localparam logic [TICK_BITS-1:0] TERMINAL = TICK_BITS'(TICK_DIV - 1);

  logic [TICK_BITS-1:0] cnt_q, cnt_d;
  logic                 t0_q, t0_d;
  logic                 overrun_q, overrun_d;
  logic                 terminal;

  // Next-state for counter, request and overrun; clear beats a same-edge tick,
  // and a tick coinciding with an acknowledge simply re-arms the request.
  always_comb begin
    terminal  = (cnt_q == TERMINAL);
    cnt_d     = cnt_q;
    t0_d      = t0_q;
    overrun_d = overrun_q;
    if (!clear_InLow) begin
      cnt_d     = '0;
      t0_d      = 1'b1;
      overrun_d = 1'b0;
    end else begin
      cnt_d = terminal ? '0 : cnt_q + TICK_BITS'(1);
      if (terminal) begin
        t0_d = 1'b0;
        if (!t0_q && load0_InLow) begin
          overrun_d = 1'b1;
        end
      end else if (!load0_InLow) begin
        t0_d = 1'b1;
      end
    end
  end

  // Prescaler, request and overrun registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      t0_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      t0_q      <= t0_d;
      overrun_q <= overrun_d;
    end
  end

  assign T0_OutLow       = t0_q;
  assign overrun_OutHigh = overrun_q;

endmodule

// File: rtl/sc_point_datapath.sv
// Point game datapath: executes the state machine's active-low strobes on the
// column pattern and row index, and hosts the T0 move-tick generator.
module sc_point_datapath
  import sc_point_datapath_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               ROWS       = DEF_ROWS,
  parameter int               ROW_BITS   = DEF_ROW_BITS,
  parameter int               TICK_DIV   = DEF_TICK_DIV,
  parameter int               TICK_BITS  = DEF_TICK_BITS,
  parameter logic [WIDTH-1:0] INIT_POINT = DEF_INIT_POINT
) (
  input  logic                SC_POINTDATAPATH_CLOCK_50,
  input  logic                SC_POINTDATAPATH_RESET_InHigh,
  sc_point_datapath_if.slave  bus
);

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  logic [WIDTH-1:0]    point_q, point_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                bottom_q, bottom_d;
  shift_sel_e          shift_sel;

  // Point/row next state: clear, then seed load, then move, then shift.
  // A move on the same cycle as a shift request drops the shift.
  always_comb begin
    point_d   = point_q;
    row_d     = row_q;
    bottom_d  = 1'b0;
    shift_sel = shift_sel_e'(bus.SC_POINTDATAPATH_shiftselection_In);
    if (!bus.SC_POINTDATAPATH_clear_InLow) begin
      point_d = INIT_POINT;
      row_d   = '0;
    end else if (!bus.SC_POINTDATAPATH_mux_In) begin
      point_d = (bus.SC_POINTDATAPATH_data_In == '0) ? INIT_POINT
                                                     : bus.SC_POINTDATAPATH_data_In;
    end else if (!bus.SC_POINTDATAPATH_load0_InLow) begin
      if (row_q == LAST_ROW) begin
        row_d    = '0;
        bottom_d = 1'b1;
      end else begin
        row_d = row_q + ROW_BITS'(1);
      end
    end else begin
      case (shift_sel)
        SHIFT_LEFT: begin
          if (!point_q[WIDTH-1]) begin
            point_d = point_q << 1;
          end
        end
        SHIFT_RIGHT: begin
          if (!point_q[0]) begin
            point_d = point_q >> 1;
          end
        end
        default: begin
          point_d = point_q;
        end
      endcase
    end
  end

  // Point, row and wrap-pulse registers with synchronous reset.
  always_ff @(posedge SC_POINTDATAPATH_CLOCK_50) begin
    if (SC_POINTDATAPATH_RESET_InHigh) begin
      point_q  <= INIT_POINT;
      row_q    <= '0;
      bottom_q <= 1'b0;
    end else begin
      point_q  <= point_d;
      row_q    <= row_d;
      bottom_q <= bottom_d;
    end
  end

  sc_tick_prescaler #(
    .TICK_DIV  (TICK_DIV),
    .TICK_BITS (TICK_BITS)
  ) u_tick (
    .clk             (SC_POINTDATAPATH_CLOCK_50),
    .rst             (SC_POINTDATAPATH_RESET_InHigh),
    .clear_InLow     (bus.SC_POINTDATAPATH_clear_InLow),
    .load0_InLow     (bus.SC_POINTDATAPATH_load0_InLow),
    .T0_OutLow       (bus.SC_POINTDATAPATH_T0_OutLow),
    .overrun_OutHigh (bus.SC_POINTDATAPATH_overrun_OutHigh)
  );

  assign bus.SC_POINTDATAPATH_point_Out      = point_q;
  assign bus.SC_POINTDATAPATH_row_Out        = row_q;
  assign bus.SC_POINTDATAPATH_bottom_OutHigh = bottom_q;

endmodule

// File: tb/tb_sc_point_datapath.sv
// Directed bench for sc_point_datapath with a short tick period; a reference
// model fills a scoreboard each cycle and fixed test-plan values are checked too.
module tb_sc_point_datapath;
  import sc_point_datapath_pkg::*;

  localparam int TB_TICK_DIV = 4;

  typedef struct {
    logic [7:0] point;
    logic [2:0] row;
    logic       t0;
    logic       bottom;
    logic       overrun;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  logic [7:0] m_point;
  logic [2:0] m_row;
  int         m_cnt;
  logic       m_pend, m_ovr, m_bottom;

  logic [7:0] left_exp  [4] = '{8'h20, 8'h40, 8'h80, 8'h80};
  logic [7:0] right_exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};

  sc_point_datapath_if #(.WIDTH(8), .ROW_BITS(3)) bus ();

  sc_point_datapath #(
    .WIDTH      (8),
    .ROWS       (8),
    .ROW_BITS   (3),
    .TICK_DIV   (TB_TICK_DIV),
    .TICK_BITS  (2),
    .INIT_POINT (8'h10)
  ) dut (
    .SC_POINTDATAPATH_CLOCK_50     (clock),
    .SC_POINTDATAPATH_RESET_InHigh (reset),
    .bus                           (bus)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic l,
                            input logic [1:0] s, input logic m, input logic [7:0] d);
    logic tc;
    if (r) begin
      m_point = 8'h10; m_row = 3'd0; m_cnt = 0;
      m_pend = 1'b0; m_ovr = 1'b0; m_bottom = 1'b0;
    end else begin
      tc = (m_cnt == TB_TICK_DIV - 1);
      m_bottom = 1'b0;
      if (!c) begin
        m_point = 8'h10; m_row = 3'd0; m_cnt = 0; m_pend = 1'b0; m_ovr = 1'b0;
      end else begin
        if (tc && m_pend && l) m_ovr = 1'b1;
        if (tc) m_pend = 1'b1;
        else if (!l) m_pend = 1'b0;
        m_cnt = tc ? 0 : m_cnt + 1;
        if (!m) begin
          m_point = (d == 8'h00) ? 8'h10 : d;
        end else if (!l) begin
          if (m_row == 3'd7) begin
            m_row = 3'd0; m_bottom = 1'b1;
          end else begin
            m_row = m_row + 3'd1;
          end
        end else if (s == 2'b01) begin
          m_point = m_point[7] ? m_point : {m_point[6:0], 1'b0};
        end else if (s == 2'b10) begin
          m_point = m_point[0] ? m_point : {1'b0, m_point[7:1]};
        end
      end
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_value({t, ".point"},   32'(bus.SC_POINTDATAPATH_point_Out),       32'(e.point));
      check_value({t, ".row"},     32'(bus.SC_POINTDATAPATH_row_Out),         32'(e.row));
      check_value({t, ".t0"},      32'(bus.SC_POINTDATAPATH_T0_OutLow),       32'(e.t0));
      check_value({t, ".bottom"},  32'(bus.SC_POINTDATAPATH_bottom_OutHigh),  32'(e.bottom));
      check_value({t, ".overrun"}, 32'(bus.SC_POINTDATAPATH_overrun_OutHigh), 32'(e.overrun));
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic c, input logic l,
                               input logic [1:0] s, input logic m, input logic [7:0] d);
    exp_t e;
    reset = r;
    bus.SC_POINTDATAPATH_clear_InLow       = c;
    bus.SC_POINTDATAPATH_load0_InLow       = l;
    bus.SC_POINTDATAPATH_shiftselection_In = s;
    bus.SC_POINTDATAPATH_mux_In            = m;
    bus.SC_POINTDATAPATH_data_In           = d;
    model_edge(r, c, l, s, m, d);
    e.point = m_point; e.row = m_row; e.t0 = ~m_pend;
    e.bottom = m_bottom; e.overrun = m_ovr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
  endtask

  task automatic do_move(input string tag, input logic [1:0] s);
    applyStimulus(tag, 1'b0, 1'b1, 1'b0, s, 1'b1, 8'h00);
  endtask

  task automatic do_clear(input string tag);
    applyStimulus(tag, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 8'h00);
  endtask

  // Directed sequence following the test plan.
  initial begin
    applyStimulus("reset", 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
    applyStimulus("reset", 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
    check_value("reset_point", 32'(bus.SC_POINTDATAPATH_point_Out), 32'h10);
    check_value("reset_t0", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);

    idle("tick_wait", 3);
    check_value("t0_before_tick", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);
    idle("tick_wait", 1);
    check_value("t0_first_low", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd0);

    do_move("ack_move", 2'b11);
    check_value("ack_row", 32'(bus.SC_POINTDATAPATH_row_Out), 32'd1);
    check_value("ack_t0_high", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);
    idle("tick_wait2", 2);
    check_value("t0_still_high", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);
    idle("tick_wait2", 1);
    check_value("t0_second_low", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd0);

    do_clear("clear_rows");
    for (int i = 0; i < 7; i++) do_move("move_seq", 2'b11);
    check_value("row_at_7", 32'(bus.SC_POINTDATAPATH_row_Out), 32'd7);
    do_move("move_wrap", 2'b11);
    check_value("wrap_row", 32'(bus.SC_POINTDATAPATH_row_Out), 32'd0);
    check_value("wrap_bottom", 32'(bus.SC_POINTDATAPATH_bottom_OutHigh), 32'd1);
    idle("after_wrap", 1);
    check_value("bottom_one_cycle", 32'(bus.SC_POINTDATAPATH_bottom_OutHigh), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus("shift_left", 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
      check_value("shift_left_const", 32'(bus.SC_POINTDATAPATH_point_Out), 32'(left_exp[i]));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus("shift_right", 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 8'h00);
      check_value("shift_right_const", 32'(bus.SC_POINTDATAPATH_point_Out), 32'(right_exp[i]));
    end
    applyStimulus("shift_00_hold", 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 8'h00);

    applyStimulus("seed_zero", 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 8'h00);
    check_value("seed_zero_const", 32'(bus.SC_POINTDATAPATH_point_Out), 32'h10);
    applyStimulus("seed_04", 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h04);
    check_value("seed_04_const", 32'(bus.SC_POINTDATAPATH_point_Out), 32'h04);
    do_move("move_drops_shift", 2'b01);
    check_value("move_drops_shift_pt", 32'(bus.SC_POINTDATAPATH_point_Out), 32'h04);
    check_value("move_drops_shift_row", 32'(bus.SC_POINTDATAPATH_row_Out), 32'd1);

    do_clear("pre_overrun");
    idle("pending", 8);
    check_value("overrun_set", 32'(bus.SC_POINTDATAPATH_overrun_OutHigh), 32'd1);
    idle("pending", 2);
    check_value("overrun_sticky", 32'(bus.SC_POINTDATAPATH_overrun_OutHigh), 32'd1);
    do_clear("clear_overrun");
    check_value("clear_overrun_const", 32'(bus.SC_POINTDATAPATH_overrun_OutHigh), 32'd0);
    check_value("clear_t0_const", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);

    idle("to_terminal", 3);
    do_clear("clear_beats_tick");
    check_value("clear_beats_tick_t0", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);
    idle("restart", 4);
    check_value("restart_t0_low", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd0);
    idle("pending_again", 3);
    do_move("ack_on_terminal", 2'b11);
    check_value("ack_on_terminal_t0", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd0);
    check_value("ack_on_terminal_ovr", 32'(bus.SC_POINTDATAPATH_overrun_OutHigh), 32'd0);

    idle("mid_count", 2);
    applyStimulus("reset_mid", 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
    check_value("reset_mid_t0", 32'(bus.SC_POINTDATAPATH_T0_OutLow), 32'd1);
    check_value("reset_mid_row", 32'(bus.SC_POINTDATAPATH_row_Out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
